sram_memory_multi: RTL and testbench
====================================

Name: sram_memory_multi

Overview:
- Parametrised behavioural model of an asynchronous-style external SRAM behind a synchronous FPGA interface. Used in simulation and FPGA builds wherever the SoC memory controller talks to off-chip SRAM.
- Generalises the single 16-bit, 1-cycle model in four ways: configurable data and address width, per-byte lane enables, configurable read latency pipeline, and a selectable read-during-write policy.
- Adds reset of the pipeline and a debug read-valid output.

Parameters:
DATA_WIDTH, 16, data bus width; must be a multiple of 8 (8..64).
ADDR_WIDTH, 18, word address width; depth = 2**ADDR_WIDTH words.
READ_LATENCY, 1, cycles from read-accept edge to data driven; legal 1..4.
WRITE_FIRST, 0, 0 = read-before-write on same-address collision, 1 = write-first (forwarded).
INIT_ZERO, 0, 1 = array initialised to 0 at time zero; 0 = array left X.

Ports:
CLOCK  input  1  sampling clock, rising edge.
RESET_n  input  1  asynchronous active-low reset; clears pipeline state only.
SRAM_CE_n  input  1  chip enable, active low.
SRAM_WE_n  input  1  write enable, active low; has priority over OE.
SRAM_OE_n  input  1  output enable, active low.
SRAM_BE_n  input  DATA_WIDTH/8  byte-lane enables, active low; bit i covers D[8i+7:8i].
SRAM_A  input  ADDR_WIDTH  word address.
SRAM_D  inout  DATA_WIDTH  bidirectional data bus.
RD_VALID  output  1  debug: high exactly when the model drives SRAM_D.

Behaviour:
- Access classification, per rising CLOCK edge:
  - write = CE_n==0 && WE_n==0
  - read = CE_n==0 && WE_n==1 && OE_n==0
  - otherwise idle.
- Write:
  - for each lane i with BE_n[i]==0, store D lane into array[A]; lanes with BE_n[i]==1 are unchanged.
  - Writes are never blocked by reset state or pipeline contents.
- Read:
  - on the accept edge, capture array[A] into pipeline stage 0 together with a valid bit.
  - BE_n is ignored for reads; the full word is returned.
  - Each subsequent edge shifts stages 0..READ_LATENCY-1; the tail stage value is the driven data.
  - READ_LATENCY=1: data is visible on D after the accept edge, identical to the legacy model.
- Pipeline when no read is accepted:
  - any edge without a read accept shifts a 0 valid bit into stage 0; data in that stage is don't-care.
  - Back-to-back reads every cycle therefore yield one result per cycle after the initial latency.
- Read-during-write: a same-address write and read cannot occur on the same edge because WE has priority. Collision is defined against in-flight pipeline entries:
  - WRITE_FIRST=0: in-flight data is not updated (value captured at accept).
  - WRITE_FIRST=1: each pipeline stage whose stored address equals A and whose valid bit is set has its enabled lanes replaced by the write data on that edge.
- Bus drive:
  - SRAM_D = tail data when tail valid==1 && CE_n==0 && OE_n==0 && WE_n==1; else high-Z.
  - RD_VALID mirrors that exact condition.
  - Deasserting OE_n or CE_n masks the drive combinationally but does not flush the pipeline; re-asserting before the entry shifts out drives it.
  - WE_n low always releases the bus, so no contention with host writes.
- Reset:
  - RESET_n low immediately clears all valid bits and stage data to 0, so SRAM_D goes high-Z and RD_VALID=0.
  - Array contents are preserved through reset.
  - A read accepted in the same cycle that reset asserts is lost.
  - Operation resumes on the first rising edge with RESET_n high.
- Address wrap: addresses are exactly ADDR_WIDTH bits; no out-of-range case exists. Address all-ones is a normal word.
- Elaboration checks: fail fatally if DATA_WIDTH%8 != 0 or READ_LATENCY is outside 1..4.

Test Plan:
- Default params: write 0xA55A to A=0x00010 with BE_n=00, then read A=0x00010 -> D=0xA55A and RD_VALID=1 one edge after the read accept; high-Z and RD_VALID=0 before it.
- Byte lanes, DATA_WIDTH=32: write 0x11223344 (BE_n=0000), then write 0xFFFFFFFF with BE_n=1010, read -> 0x11FF33FF.
- READ_LATENCY=3: back-to-back reads of A=1,2,3 holding 0x0001,0x0002,0x0003 -> D shows 1,2,3 on edges 3,4,5 after the first accept; high-Z on edges 1–2.
- WRITE_FIRST=1, READ_LATENCY=2: read A=5 (old 0x1111), next cycle write 0x2222 to A=5 -> driven value 0x2222. Same sequence with WRITE_FIRST=0 -> 0x1111.
- Reset mid-read, READ_LATENCY=3: assert RESET_n=0 one cycle after the accept -> SRAM_D high-Z and RD_VALID=0 immediately and no data appears afterwards. A subsequent read of the same address returns the pre-reset contents.
- OE masking: read accepted, then OE_n=1 on the edge the data reaches the tail -> high-Z. OE_n=0 while WE_n=0 -> bus never driven by the model.

Source files
------------

// File: rtl/sram_memory_multi.sv
// Behavioural external-SRAM model: byte-lane writes, READ_LATENCY-deep read pipeline
// with optional write-first forwarding, and a tri-state data bus with a drive indicator.
module sram_memory_multi #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 18,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          WRITE_FIRST  = 1'b0,
    parameter bit          INIT_ZERO    = 1'b0
) (
    input  logic                      CLOCK,
    input  logic                      RESET_n,
    input  logic                      SRAM_CE_n,
    input  logic                      SRAM_WE_n,
    input  logic                      SRAM_OE_n,
    input  logic [DATA_WIDTH/8-1:0]   SRAM_BE_n,
    input  logic [ADDR_WIDTH-1:0]     SRAM_A,
    inout  wire  [DATA_WIDTH-1:0]     SRAM_D,
    output logic                      RD_VALID
);

    localparam int unsigned LANES = DATA_WIDTH / 8;
    localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;
    localparam int unsigned TAIL  = READ_LATENCY - 1;

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 64) begin : g_bad_width
        $fatal(1, "sram_memory_multi: DATA_WIDTH must be a multiple of 8 in 8..64");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $fatal(1, "sram_memory_multi: READ_LATENCY must be in 1..4");
    end

    logic                  wr_c;
    logic                  rd_c;
    logic                  drive_c;
    logic [DATA_WIDTH-1:0] mem_rd;

    logic                  stage_valid [READ_LATENCY];
    logic [ADDR_WIDTH-1:0] stage_addr  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] stage_data  [READ_LATENCY];
    logic [DATA_WIDTH-1:0] stage_fwd   [READ_LATENCY];

    assign wr_c = !SRAM_CE_n && !SRAM_WE_n;
    assign rd_c = !SRAM_CE_n &&  SRAM_WE_n && !SRAM_OE_n;

    // Bus is driven only while a valid tail entry meets a live read strobe.
    assign drive_c  = stage_valid[TAIL] && rd_c;
    assign RD_VALID = drive_c;
    assign SRAM_D   = drive_c ? stage_data[TAIL] : 'z;

    // Storage array; never touched by reset.
    if (INIT_ZERO) begin : g_mem_zero
        logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

        always_ff @(posedge CLOCK) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wr_c && !SRAM_BE_n[i]) begin
                    mem[SRAM_A][8*i +: 8] <= SRAM_D[8*i +: 8];
                end
            end
        end

        assign mem_rd = mem[SRAM_A];
    end else begin : g_mem
        logic [DATA_WIDTH-1:0] mem [DEPTH];

        always_ff @(posedge CLOCK) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (wr_c && !SRAM_BE_n[i]) begin
                    mem[SRAM_A][8*i +: 8] <= SRAM_D[8*i +: 8];
                end
            end
        end

        assign mem_rd = mem[SRAM_A];
    end

    // Write-first: in-flight entries for the written word pick up the enabled lanes.
    always_comb begin
        for (int k = 0; k < int'(READ_LATENCY); k++) begin
            stage_fwd[k] = stage_data[k];
            if (WRITE_FIRST && wr_c && stage_valid[k] && (stage_addr[k] == SRAM_A)) begin
                for (int i = 0; i < int'(LANES); i++) begin
                    if (!SRAM_BE_n[i]) begin
                        stage_fwd[k][8*i +: 8] = SRAM_D[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read pipeline: stage 0 captures on accept, later stages shift every edge.
    always_ff @(posedge CLOCK or negedge RESET_n) begin
        if (!RESET_n) begin
            for (int k = 0; k < int'(READ_LATENCY); k++) begin
                stage_valid[k] <= 1'b0;
                stage_addr[k]  <= '0;
                stage_data[k]  <= '0;
            end
        end else begin
            stage_valid[0] <= rd_c;
            stage_addr[0]  <= SRAM_A;
            stage_data[0]  <= mem_rd;
            for (int k = 1; k < int'(READ_LATENCY); k++) begin
                stage_valid[k] <= stage_valid[k-1];
                stage_addr[k]  <= stage_addr[k-1];
                stage_data[k]  <= stage_fwd[k-1];
            end
        end
    end

endmodule

// File: tb/tb_sram_memory_multi.sv
// Directed bench for sram_memory_multi: five configurations share one control bus,
// each with its own data bus, checked against hand-computed values.
module tb_sram_memory_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce_n, we_n, oe_n, drv_en;
    logic [17:0] a;
    logic [1:0]  be16;
    logic [3:0]  be32;
    logic [15:0] drv16;
    logic [31:0] drv32;

    wire  [15:0] d0, d2, d3, d4;
    wire  [31:0] d1;
    logic        rv0, rv1, rv2, rv3, rv4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign d0 = drv_en ? drv16 : 'z;
    assign d2 = drv_en ? drv16 : 'z;
    assign d3 = drv_en ? drv16 : 'z;
    assign d4 = drv_en ? drv16 : 'z;
    assign d1 = drv_en ? drv32 : 'z;

    // u0: default parameters
    sram_memory_multi u0 (
        .CLOCK(clk), .RESET_n(rst_n), .SRAM_CE_n(ce_n), .SRAM_WE_n(we_n), .SRAM_OE_n(oe_n),
        .SRAM_BE_n(be16), .SRAM_A(a), .SRAM_D(d0), .RD_VALID(rv0)
    );
    // u1: 32-bit data
    sram_memory_multi #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) u1 (
        .CLOCK(clk), .RESET_n(rst_n), .SRAM_CE_n(ce_n), .SRAM_WE_n(we_n), .SRAM_OE_n(oe_n),
        .SRAM_BE_n(be32), .SRAM_A(a[7:0]), .SRAM_D(d1), .RD_VALID(rv1)
    );
    // u2: latency 3, read-before-write
    sram_memory_multi #(.ADDR_WIDTH(8), .READ_LATENCY(3)) u2 (
        .CLOCK(clk), .RESET_n(rst_n), .SRAM_CE_n(ce_n), .SRAM_WE_n(we_n), .SRAM_OE_n(oe_n),
        .SRAM_BE_n(be16), .SRAM_A(a[7:0]), .SRAM_D(d2), .RD_VALID(rv2)
    );
    // u3: latency 2, write-first
    sram_memory_multi #(.ADDR_WIDTH(8), .READ_LATENCY(2), .WRITE_FIRST(1'b1)) u3 (
        .CLOCK(clk), .RESET_n(rst_n), .SRAM_CE_n(ce_n), .SRAM_WE_n(we_n), .SRAM_OE_n(oe_n),
        .SRAM_BE_n(be16), .SRAM_A(a[7:0]), .SRAM_D(d3), .RD_VALID(rv3)
    );
    // u4: latency 2, read-before-write
    sram_memory_multi #(.ADDR_WIDTH(8), .READ_LATENCY(2), .WRITE_FIRST(1'b0)) u4 (
        .CLOCK(clk), .RESET_n(rst_n), .SRAM_CE_n(ce_n), .SRAM_WE_n(we_n), .SRAM_OE_n(oe_n),
        .SRAM_BE_n(be16), .SRAM_A(a[7:0]), .SRAM_D(d4), .RD_VALID(rv4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; drv_en = 1'b0;
        be16 = 2'b11; be32 = 4'hF;
    endtask

    task automatic wr16(input logic [17:0] addr, input logic [15:0] data);
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; drv_en = 1'b1;
        a = addr; drv16 = data; be16 = 2'b00; be32 = 4'hF;
    endtask

    task automatic rd(input logic [17:0] addr);
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; drv_en = 1'b0;
        a = addr;
    endtask

    initial begin
        rst_n = 1'b0;
        a = '0; drv16 = '0; drv32 = '0;
        idle();
        repeat (2) tick();
        check("reset_rv0", 32'(rv0), 32'd0);
        check("reset_rv1", 32'(rv1), 32'd0);
        check("reset_rv2", 32'(rv2), 32'd0);
        check("reset_rv3", 32'(rv3), 32'd0);
        check("reset_rv4", 32'(rv4), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic write then latency-1 read
        wr16(18'h00010, 16'hA55A);
        tick();
        rd(18'h00010);
        #1;
        check("t1_pre_rv0", 32'(rv0), 32'd0);
        tick();
        check("t1_rv0", 32'(rv0), 32'd1);
        check("t1_d0", 32'(d0), 32'h0000A55A);
        check("t1_rv3_not_yet", 32'(rv3), 32'd0);
        idle();
        tick();
        check("t1_after_rv0", 32'(rv0), 32'd0);

        // Address all-ones is an ordinary word
        wr16(18'h3FFFF, 16'h5A5A);
        tick();
        rd(18'h3FFFF);
        tick();
        check("wrap_rv0", 32'(rv0), 32'd1);
        check("wrap_d0", 32'(d0), 32'h00005A5A);
        idle();
        tick();

        // Byte lanes on the 32-bit instance
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; drv_en = 1'b1;
        a = 18'h00020; be16 = 2'b11; be32 = 4'b0000; drv32 = 32'h11223344;
        tick();
        be32 = 4'b1010; drv32 = 32'hFFFFFFFF;
        tick();
        rd(18'h00020);
        tick();
        check("lanes_rv1", 32'(rv1), 32'd1);
        check("lanes_d1", 32'(d1), 32'h11FF33FF);
        idle();
        tick();

        // Latency 3, back-to-back reads
        wr16(18'd1, 16'h0001); tick();
        wr16(18'd2, 16'h0002); tick();
        wr16(18'd3, 16'h0003); tick();
        rd(18'd1); tick();
        check("lat3_e1_rv2", 32'(rv2), 32'd0);
        rd(18'd2); tick();
        check("lat3_e2_rv2", 32'(rv2), 32'd0);
        rd(18'd3); tick();
        check("lat3_e3_rv2", 32'(rv2), 32'd1);
        check("lat3_e3_d2", 32'(d2), 32'h00000001);
        rd(18'h00040); tick();
        check("lat3_e4_d2", 32'(d2), 32'h00000002);
        tick();
        check("lat3_e5_rv2", 32'(rv2), 32'd1);
        check("lat3_e5_d2", 32'(d2), 32'h00000003);
        idle();
        #1;
        check("lat3_ce_mask_rv2", 32'(rv2), 32'd0);
        repeat (3) tick();

        // Read-during-write on in-flight entries
        wr16(18'd5, 16'h1111); tick();
        rd(18'd5); tick();
        wr16(18'd5, 16'h2222); tick();
        rd(18'h00041);
        #1;
        check("wf1_rv3", 32'(rv3), 32'd1);
        check("wf1_d3", 32'(d3), 32'h00002222);
        check("wf0_rv4", 32'(rv4), 32'd1);
        check("wf0_d4", 32'(d4), 32'h00001111);
        tick();
        check("wf0_lat3_d2", 32'(d2), 32'h00001111);
        rd(18'd5); tick(); tick();
        check("wf1_array_d3", 32'(d3), 32'h00002222);
        check("wf0_array_d4", 32'(d4), 32'h00002222);
        idle();
        repeat (4) tick();

        // Reset mid-read, latency 3
        rd(18'h00010); tick(); tick();
        check("rst_pre_rv0", 32'(rv0), 32'd1);
        check("rst_pre_rv3", 32'(rv3), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_now_rv0", 32'(rv0), 32'd0);
        check("rst_now_rv2", 32'(rv2), 32'd0);
        check("rst_now_rv3", 32'(rv3), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_e1_rv2", 32'(rv2), 32'd0);
        tick();
        check("rst_e2_rv2", 32'(rv2), 32'd0);
        tick();
        check("rst_e3_rv2", 32'(rv2), 32'd1);
        check("rst_e3_d2", 32'(d2), 32'h0000A55A);
        idle();
        repeat (4) tick();

        // OE masking and WE release, latency 3
        rd(18'h00010); tick();
        ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b1;
        tick(); tick();
        check("oe_mask_rv2", 32'(rv2), 32'd0);
        oe_n = 1'b0;
        #1;
        check("oe_reassert_rv2", 32'(rv2), 32'd1);
        check("oe_reassert_d2", 32'(d2), 32'h0000A55A);
        we_n = 1'b0; be16 = 2'b11; be32 = 4'hF; drv16 = 16'hBEEF; drv_en = 1'b1;
        #1;
        check("we_release_rv2", 32'(rv2), 32'd0);
        check("we_release_d2", 32'(d2), 32'h0000BEEF);
        tick();
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
